// File: rtl/pipeline_pkg.sv
// Shared definitions for the generic inter-stage pipeline register chain.
//   - Payload structs for the classic IF/ID, ID/EX, EX/MEM and MEM/WB boundaries
//     and their bit widths, so a producer can pack them into in_data.
//   - MAX_STAGES: the deepest chain that may be built.
//   - occ_width(): width of the occupancy counter for a given chain shape.
package pipeline_pkg;

  localparam int MAX_STAGES = 8;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        jal;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic [31:0] pc_4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        jal;
    logic [4:0]  rd_addr;
    logic [31:0] pc_4;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } ex_mem_t;

  // 1 + 5 + 1 + 1 + 32 + 32 = 72 bits
  typedef struct packed {
    logic        jal;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] pc_4;
    logic [31:0] mem_data;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // Enough bits to count every entry of the chain, including the empty state.
  function automatic int occ_width(input int stages, input int skid);
    return $clog2(stages * (skid + 1) + 1);
  endfunction

endpackage

// File: rtl/pipeline_stage_chain_if.sv
// Valid/ready/data bundle used on both sides of the pipeline register chain.
//   valid : beat present (driven by the master)
//   ready : beat accepted on this edge when valid is also high (driven by the slave)
//   data  : DATA_WIDTH payload (driven by the master)
interface pipeline_stage_chain_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_slice.sv
// One register slice of the pipeline chain.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   flush          : synchronous squash of every beat held by this slice
//   valid_up/ready_up/data_up       : upstream handshake
//   valid_down/ready_down/data_down : downstream handshake
// SKID=0 holds one beat and passes ready back combinationally.
// SKID=1 adds a skid entry so ready_up comes straight from a flop.
module pipeline_slice
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SKID       = 0,
  parameter int CLEAR_DATA = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  valid_up,
  output logic                  ready_up,
  input  logic [DATA_WIDTH-1:0] data_up,
  output logic                  valid_down,
  input  logic                  ready_down,
  output logic [DATA_WIDTH-1:0] data_down
);

  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;

  assign valid_down = main_valid;
  assign data_down  = main_data;

  if (SKID == 0) begin : g_plain
    // Empty, or the held beat leaves on this edge: a new beat may enter.
    assign ready_up = !main_valid || ready_down;

    // Single-entry register: load whenever the slot is free or being vacated.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        if (CLEAR_DATA != 0) main_data <= '0;
      end else if (ready_up) begin
        main_valid <= valid_up;
        if (valid_up) main_data <= data_up;
      end
    end
  end else begin : g_skid
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  accept;
    logic                  take;

    // ready_up depends only on a flop, breaking the out_ready -> in_ready path.
    // skid_valid implies main_valid, so accepting never overwrites a beat.
    assign ready_up = !skid_valid;
    assign accept   = valid_up && !skid_valid;
    assign take     = main_valid && ready_down;

    // Main/skid pair: overflow goes to skid, skid refills main when main drains.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        if (CLEAR_DATA != 0) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else if (take) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_data <= data_up;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_data  <= data_up;
          skid_valid <= 1'b1;
        end else begin
          main_data  <= data_up;
          main_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_stage_chain.sv
// Generic inter-stage pipeline register: STAGES chained slices under valid/ready.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   in_bus         : producer side (slave modport): valid, data in; ready out
//   out_bus        : consumer side (master modport): valid, data out; ready in
//   flush          : squash every in-flight beat; blocks acceptance this cycle
//   occupancy      : number of beats currently held in the chain
module pipeline_stage_chain
  import pipeline_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int STAGES     = 1,
  parameter  int SKID       = 0,
  parameter  int CLEAR_DATA = 0,
  localparam int OCC_W      = occ_width(STAGES, SKID)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  pipeline_stage_chain_if.slave  in_bus,
  pipeline_stage_chain_if.master out_bus,
  input  logic                   flush,
  output logic [OCC_W-1:0]       occupancy
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $error("pipeline_stage_chain: DATA_WIDTH %0d outside 1..1024", DATA_WIDTH);
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("pipeline_stage_chain: STAGES %0d outside 1..%0d", STAGES, MAX_STAGES);
  end
  if (SKID != 0 && SKID != 1) begin : g_bad_skid
    $error("pipeline_stage_chain: SKID must be 0 or 1");
  end
  if (CLEAR_DATA != 0 && CLEAR_DATA != 1) begin : g_bad_clear
    $error("pipeline_stage_chain: CLEAR_DATA must be 0 or 1");
  end

  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic                  ready_en;
  logic [STAGES:0]       vld;
  logic [DATA_WIDTH-1:0] dat [0:STAGES];
  logic                  accept;
  logic                  emit;
  logic [OCC_W-1:0]      occ_next;

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign vld[0]        = in_bus.valid && ready_en;
  assign dat[0]        = in_bus.data;
  assign in_bus.ready  = g_stage[0].st_ready && ready_en && !flush;
  assign out_bus.valid = vld[STAGES];
  assign out_bus.data  = dat[STAGES];

  // Each stage keeps its own ready net so the backward ready chain is a set of
  // separate signals rather than one self-dependent vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic st_ready;
    logic dn_ready;

    if (i == STAGES - 1) begin : g_last
      assign dn_ready = out_bus.ready;
    end else begin : g_mid
      assign dn_ready = g_stage[i+1].st_ready;
    end

    pipeline_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .SKID       (SKID),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_slice (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (flush),
      .valid_up   (vld[i]),
      .ready_up   (st_ready),
      .data_up    (dat[i]),
      .valid_down (vld[i+1]),
      .ready_down (dn_ready),
      .data_down  (dat[i+1])
    );
  end

  assign accept = in_bus.valid && in_bus.ready;
  assign emit   = out_bus.valid && out_bus.ready;

  // Occupancy update: an accept and an emit on the same edge cancel out.
  always_comb begin
    occ_next = occupancy;
    if (flush) begin
      occ_next = '0;
    end else begin
      case ({accept, emit})
        2'b10:   occ_next = occupancy + OCC_ONE;
        2'b01:   occ_next = occupancy - OCC_ONE;
        default: occ_next = occupancy;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Bench for pipeline_stage_chain.
//   dut_a: STAGES=3, SKID=0 (table-driven streaming/stall/flush/simultaneous, reset)
//   dut_b: STAGES=2, SKID=1, CLEAR_DATA=1 (stall with skid, flush)
//   Both run a randomized valid/ready phase against queue scoreboards.
module tb_pipeline_stage_chain;
  import pipeline_pkg::*;

  localparam int OCC_A = occ_width(3, 0);
  localparam int OCC_B = occ_width(2, 1);

  logic             clock;
  logic             reset_n;
  logic             flush_a;
  logic             flush_b;
  logic [OCC_A-1:0] occ_a;
  logic [OCC_B-1:0] occ_b;

  pipeline_stage_chain_if #(.DATA_WIDTH(32)) ia_in  ();
  pipeline_stage_chain_if #(.DATA_WIDTH(32)) ia_out ();
  pipeline_stage_chain_if #(.DATA_WIDTH(32)) ib_in  ();
  pipeline_stage_chain_if #(.DATA_WIDTH(32)) ib_out ();

  pipeline_stage_chain #(.DATA_WIDTH(32), .STAGES(3), .SKID(0), .CLEAR_DATA(0)) dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_bus    (ia_in),
    .out_bus   (ia_out),
    .flush     (flush_a),
    .occupancy (occ_a)
  );

  pipeline_stage_chain #(.DATA_WIDTH(32), .STAGES(2), .SKID(1), .CLEAR_DATA(1)) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_bus    (ib_in),
    .out_bus   (ib_out),
    .flush     (flush_b),
    .occupancy (occ_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl [14];
  int idx;
  int k;
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic acc_a, fire_a, acc_b, fire_b;

  initial begin
    // iv, data, out_ready, flush | in_ready(pre-edge), out_valid, out_data, occupancy (post-edge)
    tbl[0]  = '{1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1};
    tbl[1]  = '{1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2};
    tbl[2]  = '{1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 2'd3};
    tbl[3]  = '{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 2'd3};
    tbl[4]  = '{1'b1, 32'h5,  1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 2'd3};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3, 2'd2};
    tbl[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 2'd2};
    tbl[7]  = '{1'b1, 32'h6,  1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 2'd3};
    tbl[8]  = '{1'b1, 32'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0};
    tbl[10] = '{1'b1, 32'h7,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h7, 2'd1};
    tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0};

    reset_n = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    ia_in.valid = 1'b0; ia_in.data = 32'h0; ia_out.ready = 1'b0;
    ib_in.valid = 1'b0; ib_in.data = 32'h0; ib_out.ready = 1'b0;

    // Reset state
    #3;
    chk("rst_a_out_valid", ia_out.valid, 1'b0);
    chk("rst_a_occ", occ_a, 2'd0);
    chk("rst_a_in_ready", ia_in.ready, 1'b0);
    chk("rst_b_out_valid", ib_out.valid, 1'b0);
    chk("rst_b_occ", occ_b, 3'd0);
    chk("rst_b_in_ready", ib_in.ready, 1'b0);
    #9 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_a_in_ready", ia_in.ready, 1'b1);
    chk("post_rst_b_in_ready", ib_in.ready, 1'b1);

    // Table-driven run on dut_a
    for (int i = 0; i < 14; i++) begin
      ia_in.valid  = tbl[i].iv;
      ia_in.data   = tbl[i].d;
      ia_out.ready = tbl[i].ordy;
      flush_a      = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), ia_in.ready, tbl[i].e_ir);
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_out_valid", i), ia_out.valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), ia_out.data, tbl[i].e_od);
      chk($sformatf("tbl%0d_occ", i), occ_a, tbl[i].e_occ);
    end
    ia_in.valid = 1'b0; flush_a = 1'b0;

    // dut_b stall: 6 cycles of out_ready=0 while offering 0xA0..0xA5
    ib_out.ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      ib_in.valid = 1'b1;
      ib_in.data  = 32'(32'hA0 + idx);
      #1;
      chk($sformatf("stall%0d_in_ready", c), ib_in.ready, (c < 4));
      if (ib_in.ready) idx++;
      @(posedge clock); #1;
    end
    chk("stall_accepts", idx, 4);
    chk("stall_occ", occ_b, 3'd4);
    chk("stall_out_valid", ib_out.valid, 1'b1);
    chk("stall_out_data", ib_out.data, 32'hA0);
    // release: remaining beats keep coming, everything drains in order
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      ib_in.valid  = (idx < 6);
      ib_in.data   = 32'(32'hA0 + idx);
      ib_out.ready = 1'b1;
      #1;
      if (ib_out.valid) begin
        chk($sformatf("release%0d_data", k), ib_out.data, 32'(32'hA0 + k));
        k++;
      end
      if (ib_in.valid && ib_in.ready) idx++;
      @(posedge clock); #1;
    end
    chk("release_count", k, 6);
    ib_in.valid = 1'b0;
    chk("release_occ", occ_b, 3'd0);

    // dut_b flush with 3 beats held and a beat offered in the flush cycle
    ib_out.ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ib_in.valid = 1'b1;
      ib_in.data  = 32'(32'hB0 + c);
      @(posedge clock); #1;
    end
    chk("flush_pre_occ", occ_b, 3'd3);
    ib_in.valid = 1'b1; ib_in.data = 32'hFF; ib_out.ready = 1'b1; flush_b = 1'b1;
    #1;
    chk("flush_in_ready", ib_in.ready, 1'b0);
    @(posedge clock); #1;
    flush_b = 1'b0; ib_in.valid = 1'b0;
    chk("flush_occ", occ_b, 3'd0);
    chk("flush_out_valid", ib_out.valid, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      chk($sformatf("flush_after%0d_out_valid", c), ib_out.valid, 1'b0);
    end

    // Reset mid-stream on dut_a with 2 beats in flight
    ia_out.ready = 1'b0;
    ia_in.valid = 1'b1; ia_in.data = 32'h11;
    @(posedge clock); #1;
    ia_in.data = 32'h12;
    @(posedge clock); #1;
    chk("midrst_pre_occ", occ_a, 2'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", ia_out.valid, 1'b0);
    chk("midrst_occ", occ_a, 2'd0);
    chk("midrst_in_ready", ia_in.ready, 1'b0);
    @(posedge clock); #3;
    reset_n = 1'b1;
    ia_in.valid = 1'b0; ia_out.ready = 1'b1;
    @(posedge clock); #1;
    chk("midrst_release_in_ready", ia_in.ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      chk($sformatf("midrst_after%0d_out_valid", c), ia_out.valid, 1'b0);
    end

    // Random valid/ready against queue scoreboards
    for (int c = 0; c < 10000; c++) begin
      ia_in.valid  = 1'($urandom_range(0, 1));
      ia_in.data   = $urandom;
      ia_out.ready = 1'($urandom_range(0, 1));
      ib_in.valid  = 1'($urandom_range(0, 1));
      ib_in.data   = $urandom;
      ib_out.ready = 1'($urandom_range(0, 1));
      #1;
      acc_a  = ia_in.valid && ia_in.ready;
      fire_a = ia_out.valid && ia_out.ready;
      acc_b  = ib_in.valid && ib_in.ready;
      fire_b = ib_out.valid && ib_out.ready;
      if (fire_a) begin
        chk("rand_a_nonempty", (qa.size() != 0), 1'b1);
        if (qa.size() != 0) begin
          chk("rand_a_data", ia_out.data, qa[0]);
          void'(qa.pop_front());
        end
      end
      if (fire_b) begin
        chk("rand_b_nonempty", (qb.size() != 0), 1'b1);
        if (qb.size() != 0) begin
          chk("rand_b_data", ib_out.data, qb[0]);
          void'(qb.pop_front());
        end
      end
      if (acc_a) qa.push_back(ia_in.data);
      if (acc_b) qb.push_back(ib_in.data);
      @(posedge clock); #1;
      chk("rand_a_occ", occ_a, qa.size());
      chk("rand_b_occ", occ_b, qb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
